// File: rtl/tdm_serializer_if.sv
// Frame-in / word-out handshake bundle for tdm_serializer.
// slave = serializer side, master = upstream/downstream environment side.
interface tdm_serializer_if #(
  parameter int N_CHANNELS = 2,
  parameter int DATA_WIDTH = 32
);
  localparam int CW = $clog2(N_CHANNELS);

  logic [N_CHANNELS*DATA_WIDTH-1:0] in;
  logic                             in_valid;
  logic                             in_ready;
  logic [DATA_WIDTH-1:0]            out;
  logic [CW-1:0]                    out_channel;
  logic                             out_valid;
  logic                             out_last;
  logic                             out_ready;

  modport slave (
    input  in, in_valid, out_ready,
    output in_ready, out, out_channel, out_valid, out_last
  );

  modport master (
    output in, in_valid, out_ready,
    input  in_ready, out, out_channel, out_valid, out_last
  );
endinterface

// File: rtl/tdm_serializer.sv
// N-channel TDM serializer: active frame A shifts out one word per transfer, holding frame H
// gives gapless streaming. Define TDM_SERIALIZER_DROP_CNT_EN to add drop_pulse/drop_count ports.
module tdm_serializer #(
  parameter int N_CHANNELS = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  tdm_serializer_if.slave   bus
`ifdef TDM_SERIALIZER_DROP_CNT_EN
  ,
  output logic              drop_pulse,
  output logic [15:0]       drop_count
`endif
);

  localparam int CW = $clog2(N_CHANNELS);
  localparam int FW = N_CHANNELS * DATA_WIDTH;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [CW-1:0] LAST_CH = CW'(N_CHANNELS - 1);

  if (N_CHANNELS < 2) begin : g_param_check
    $error("tdm_serializer: N_CHANNELS must be >= 2");
  end

  logic [0:0]    state_q, state_d;
  logic [FW-1:0] a_q, a_d;
  logic [FW-1:0] h_q, h_d;
  logic          h_full_q, h_full_d;
  logic [CW-1:0] chan_q, chan_d;

  logic accept;
  logic xfer;
  logic last_xfer;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    h_d       = h_q;
    h_full_d  = h_full_q;
    chan_d    = chan_q;
    accept    = bus.in_valid && !h_full_q;
    xfer      = (state_q == ST_SHIFT) && bus.out_ready;
    last_xfer = xfer && (chan_q == LAST_CH);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = bus.in;
          chan_d  = '0;
          state_d = ST_SHIFT;
        end
      end
      default: begin
        if (last_xfer) begin
          // Refill A on the same edge the last word leaves, so no bubble appears.
          chan_d = '0;
          if (h_full_q) begin
            a_d      = h_q;
            h_full_d = 1'b0;
          end else if (accept) begin
            a_d = bus.in;
          end else begin
            a_d     = '0;
            state_d = ST_IDLE;
          end
        end else begin
          if (xfer) begin
            a_d    = a_q << DATA_WIDTH;
            chan_d = chan_q + 1'b1;
          end
          if (accept) begin
            h_d      = bus.in;
            h_full_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      h_q      <= '0;
      h_full_q <= 1'b0;
      chan_q   <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      h_q      <= h_d;
      h_full_q <= h_full_d;
      chan_q   <= chan_d;
    end
  end

  // The current word is always the top slice of A; A shifts left on each transfer.
  assign bus.out         = a_q[FW-1 -: DATA_WIDTH];
  assign bus.out_channel = chan_q;
  assign bus.out_valid   = (state_q == ST_SHIFT);
  assign bus.out_last    = (state_q == ST_SHIFT) && (chan_q == LAST_CH);
  assign bus.in_ready    = !h_full_q;

`ifdef TDM_SERIALIZER_DROP_CNT_EN
  logic        drop_pulse_q;
  logic [15:0] drop_count_q, drop_count_d;
  logic        drop;

  always_comb begin
    drop         = bus.in_valid && h_full_q;
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_pulse_q <= 1'b0;
      drop_count_q <= 16'd0;
    end else begin
      drop_pulse_q <= drop;
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_pulse = drop_pulse_q;
  assign drop_count = drop_count_q;
`endif

endmodule
